// File: rtl/result_tx_pkg.sv
// Shared types and default sizing for the result vector serializer.
package result_tx_pkg;

    localparam int D_MODEL_DEF    = 64;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int IDX_W          = $clog2(D_MODEL_DEF + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/result_stream_tx.sv
// Captures one D_MODEL-element result vector and streams it word by word over valid/ready.
// Define RESULT_TX_CHECKSUM_EN to append an XOR checksum word to every frame.
module result_stream_tx
    import result_tx_pkg::*;
#(
    parameter int D_MODEL    = D_MODEL_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vec_valid_in,
    input  logic [D_MODEL*DATA_WIDTH-1:0] vec_data_in,
    output logic                          vec_ready_out,
    output logic [DATA_WIDTH-1:0]         spi_word_out,
    output logic                          spi_word_valid_out,
    input  logic                          spi_word_ready_in,
    output logic                          spi_word_last_out,
    output logic                          busy_out,
    output logic                          frame_done_out
);

`ifdef RESULT_TX_CHECKSUM_EN
    localparam int IW = $clog2(D_MODEL + 1);
    localparam logic [IW-1:0] CSUM_IDX = IW'(D_MODEL);
`else
    localparam int IW = $clog2(D_MODEL);
`endif
    localparam logic [IW-1:0] LAST_DATA_IDX = IW'(D_MODEL - 1);

    state_t                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d, idx_inc;
    logic [D_MODEL*DATA_WIDTH-1:0]   shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0]           word_q, word_d;
    logic                            valid_q, valid_d;
    logic                            last_q, last_d;
    logic                            ready_q, ready_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            frame_end;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]           csum_q, csum_d;
`endif

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = valid_q;
        last_d   = last_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        idx_inc  = idx_q + 1'b1;
`ifdef RESULT_TX_CHECKSUM_EN
        csum_d    = csum_q;
        frame_end = (idx_q == CSUM_IDX);
`else
        frame_end = (idx_q == LAST_DATA_IDX);
`endif

        unique case (state_q)
            IDLE: begin
                if (vec_valid_in && ready_q) begin
                    state_d  = SEND;
                    shadow_d = vec_data_in;
                    idx_d    = '0;
                    word_d   = vec_data_in[DATA_WIDTH-1:0];
                    valid_d  = 1'b1;
                    last_d   = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
`ifdef RESULT_TX_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            SEND: begin
                if (valid_q && spi_word_ready_in) begin
                    if (frame_end) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        word_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_inc;
`ifdef RESULT_TX_CHECKSUM_EN
                        csum_d = csum_q ^ word_q;
                        if (idx_q == LAST_DATA_IDX) begin
                            // Checksum word folds in the data word being accepted now.
                            word_d = csum_q ^ word_q;
                            last_d = 1'b1;
                        end else begin
                            word_d = shadow_q[idx_inc*DATA_WIDTH +: DATA_WIDTH];
                            last_d = 1'b0;
                        end
`else
                        word_d = shadow_q[idx_inc*DATA_WIDTH +: DATA_WIDTH];
                        last_d = (idx_inc == LAST_DATA_IDX);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the shadow register is
    // reset as well so a fresh device never presents stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef RESULT_TX_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign vec_ready_out      = ready_q;
    assign spi_word_out       = word_q;
    assign spi_word_valid_out = valid_q;
    assign spi_word_last_out  = last_q;
    assign busy_out           = busy_q;
    assign frame_done_out     = done_q;

endmodule

// File: tb/tb_result_stream_tx.sv
// Scoreboard bench for result_stream_tx; honours RESULT_TX_CHECKSUM_EN when defined.
module tb_result_stream_tx;
    import result_tx_pkg::*;

    localparam int DM = D_MODEL_DEF;
    localparam int DW = DATA_WIDTH_DEF;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int FRAME_LEN = DM + 1;
`else
    localparam int FRAME_LEN = DM;
`endif
    localparam int BUDGET = 2000;

    typedef struct packed {
        logic [DW-1:0] word;
        logic          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             vec_valid_in;
    logic [DM*DW-1:0] vec_data_in;
    logic             vec_ready_out;
    logic [DW-1:0]    spi_word_out;
    logic             spi_word_valid_out;
    logic             spi_word_ready_in = 1'b1;
    logic             spi_word_last_out;
    logic             busy_out;
    logic             frame_done_out;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_count = 0;
    int   ready_mode = 0;

    result_stream_tx #(.D_MODEL(DM), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .vec_valid_in      (vec_valid_in),
        .vec_data_in       (vec_data_in),
        .vec_ready_out     (vec_ready_out),
        .spi_word_out      (spi_word_out),
        .spi_word_valid_out(spi_word_valid_out),
        .spi_word_ready_in (spi_word_ready_in),
        .spi_word_last_out (spi_word_last_out),
        .busy_out          (busy_out),
        .frame_done_out    (frame_done_out)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DM*DW-1:0] ramp(input logic [DW-1:0] base);
        logic [DM*DW-1:0] v;
        for (int i = 0; i < DM; i++) v[i*DW +: DW] = base + DW'(i);
        return v;
    endfunction

    function automatic void push_frame(input logic [DM*DW-1:0] v);
        exp_t          e;
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < DM; i++) begin
            e.word = v[i*DW +: DW];
            x      = x ^ e.word;
`ifdef RESULT_TX_CHECKSUM_EN
            e.last = 1'b0;
`else
            e.last = (i == DM - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef RESULT_TX_CHECKSUM_EN
        e.word = x;
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vec_ready"}, vec_ready_out, 1);
        check({tag, "_valid"}, spi_word_valid_out, 0);
        check({tag, "_word"}, spi_word_out, 0);
        check({tag, "_last"}, spi_word_last_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_done"}, frame_done_out, 0);
    endtask

    task automatic offer(input logic [DM*DW-1:0] v);
        @(posedge clk); #1;
        vec_data_in  = v;
        vec_valid_in = 1'b1;
        push_frame(v);
        hs_count = 0;
        @(posedge clk); #1;
        vec_valid_in = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!frame_done_out && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= BUDGET) check("frame_done_timeout", 0, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("ready_after_frame", vec_ready_out, 1);
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check("handshake_timeout", hs_count, target);
    endtask

    // Ready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1, mode 2 stalled.
    initial begin
        int         cyc;
        logic [3:0] pat;
        cyc = 0;
        pat = 4'b1001;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (ready_mode)
                0:       spi_word_ready_in = 1'b1;
                1:       spi_word_ready_in = pat[cyc % 4];
                default: spi_word_ready_in = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability and frame_done.
    initial begin
        exp_t          e;
        logic          stalled, last_hs, st_last;
        logic [DW-1:0] st_word;
        stalled = 1'b0;
        last_hs = 1'b0;
        st_last = 1'b0;
        st_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                last_hs = 1'b0;
            end else begin
                if (frame_done_out || last_hs) check("frame_done", frame_done_out, last_hs);
                if (stalled) begin
                    check("valid_held", spi_word_valid_out, 1);
                    check("stall_stable", {spi_word_out, spi_word_last_out}, {st_word, st_last});
                end
                stalled = 1'b0;
                last_hs = 1'b0;
                if (spi_word_valid_out && spi_word_ready_in) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h with nothing expected", spi_word_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_last", {spi_word_out, spi_word_last_out}, {e.word, e.last});
                        last_hs = e.last;
                    end
                end else if (spi_word_valid_out) begin
                    stalled = 1'b1;
                    st_word = spi_word_out;
                    st_last = spi_word_last_out;
                end
            end
        end
    end

    initial begin
        int               cyc;
        logic [DM*DW-1:0] v;
        rst_n        = 1'b0;
        vec_valid_in = 1'b0;
        vec_data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Full-rate frame: first word one cycle after capture, one word per cycle.
        offer(ramp(16'h1000));
        check("latency_valid", spi_word_valid_out, 1);
        check("latency_word", spi_word_out, 16'h1000);
        check("busy_in_frame", busy_out, 1);
        check("ready_low_in_frame", vec_ready_out, 0);
        wait_done(cyc);
        check("frame_cycles", cyc, FRAME_LEN);

        // Ready toggling 1,0,0,1.
        ready_mode = 1;
        offer(ramp(16'h1000));
        wait_done(cyc);
        ready_mode = 0;

        // New vector offered mid-frame must be ignored.
        offer(ramp(16'h5000));
        wait_hs(10);
        @(posedge clk); #1;
        vec_data_in  = ramp(16'h7000);
        vec_valid_in = 1'b1;
        check("ignore_ready_low", vec_ready_out, 0);
        check("ignore_busy", busy_out, 1);
        @(posedge clk); #1;
        vec_valid_in = 1'b0;
        check("ignore_ready_still_low", vec_ready_out, 0);
        wait_done(cyc);

        // Reset at word 30 abandons the frame.
        offer(ramp(16'h4000));
        wait_hs(30);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        offer(ramp(16'hA000));
        check("after_reset_word0", spi_word_out, 16'hA000);
        wait_done(cyc);

        // Vector offered in the frame_done cycle is accepted immediately.
        offer(ramp(16'h2000));
        wait_done(cyc);
        check("b2b_done_seen", frame_done_out, 1);
        vec_data_in  = ramp(16'h3000);
        vec_valid_in = 1'b1;
        push_frame(ramp(16'h3000));
        hs_count = 0;
        @(posedge clk); #1;
        vec_valid_in = 1'b0;
        check("b2b_valid", spi_word_valid_out, 1);
        check("b2b_word0", spi_word_out, 16'h3000);
        wait_done(cyc);
        check("b2b_frame_cycles", cyc, FRAME_LEN);

        // Element i = i (XOR of data words is zero), with a long stall at the start.
        ready_mode = 2;
        offer(ramp(16'h0000));
        repeat (20) @(posedge clk);
        #1;
        check("long_stall_valid", spi_word_valid_out, 1);
        check("long_stall_word", spi_word_out, 16'h0000);
        ready_mode = 0;
        wait_done(cyc);

        // Single all-ones element: checksum equals that element.
        v = '0;
        v[DW-1:0] = 16'hFFFF;
        offer(v);
        wait_done(cyc);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_stream_tx.md
Name: result_stream_tx

Overview:
Transmit-side counterpart of the SPI word-input path. Accepts one full D_MODEL-element result vector, for example the LayerNorm output, in parallel. Serializes it as DATA_WIDTH-bit words over a valid/ready word interface feeding the SPI transmit shifter. Sits between the streaming controller's result_out/result_valid and the SPI output logic.

Parameters:
D_MODEL, 64, elements per vector (words per frame), >= 2
DATA_WIDTH, 16, bits per element/word

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
vec_valid_in  input  1  result vector available
vec_data_in  input  D_MODEL*DATA_WIDTH  flat result vector; element i = bits [i*DATA_WIDTH +: DATA_WIDTH]
vec_ready_out  output  1  block can capture a vector
spi_word_out  output  DATA_WIDTH  current outgoing word
spi_word_valid_out  output  1  spi_word_out valid
spi_word_ready_in  input  1  downstream SPI shifter accepts word
spi_word_last_out  output  1  high with the final word of the frame
busy_out  output  1  frame in progress
frame_done_out  output  1  one-cycle pulse after the final word handshake

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, index=0, shadow register=0
  - vec_ready_out=1, spi_word_valid_out=0, spi_word_out=0, spi_word_last_out=0, busy_out=0, frame_done_out=0
- States: IDLE, SEND.
- IDLE:
  - vec_ready_out=1.
  - On vec_valid_in&vec_ready_out, capture vec_data_in into the shadow register, set index=0, go to SEND.
  - spi_word_valid_out rises the next cycle with element 0 (1-cycle latency).
- SEND:
  - vec_ready_out=0, busy_out=1, spi_word_valid_out=1, spi_word_out=shadow[index].
  - Word handshake = valid&ready.
  - On a handshake with index<D_MODEL-1: index+1. The next word is presented the following cycle, so back-to-back handshakes give one word per cycle.
  - spi_word_last_out=1 iff index==D_MODEL-1.
  - On a handshake of the last word: go to IDLE. In that next cycle frame_done_out=1 (for exactly one cycle) and vec_ready_out=1.
- Handshake rules:
  - spi_word_out and spi_word_last_out hold stable while valid&!ready.
  - Valid never drops before its handshake.
- Word order: element 0 first, ascending index.
- Boundary conditions:
  - vec_valid_in while busy is ignored; the shadow register is not overwritten.
  - A vector offered in the frame_done_out cycle is accepted, giving a minimum 1-cycle gap between frames.
  - spi_word_ready_in held low stalls indefinitely with no timeout.
  - Reset mid-frame abandons the frame immediately: outputs return to reset values and no frame_done_out pulse is produced.
  - index width = clog2(D_MODEL); index never exceeds D_MODEL-1.
- All outputs are registered.

Optional Feature:
Macro: RESULT_TX_CHECKSUM_EN
- Defined:
  - After the last data word, one extra word is sent: the XOR of all D_MODEL data words.
  - spi_word_last_out is asserted on the checksum word and not on word D_MODEL-1.
  - frame_done_out pulses after the checksum handshake.
  - The frame is D_MODEL+1 words; the accumulator clears on vector capture.
- Undefined: frame is exactly D_MODEL words and there is no checksum logic.

Decomposition:
- Package result_tx_pkg:
  - D_MODEL/DATA_WIDTH defaults
  - IDX_W = clog2(D_MODEL+1)
  - state enum {IDLE, SEND}
  - word typedef logic [DATA_WIDTH-1:0]
- No sub-module needed: word selection is an indexed part-select of the shadow register, and the checksum is an inline XOR accumulator.

Test Plan:
- Reset, then a vector with element i = 16'h1000+i and ready tied high -> words 0x1000..0x103F on consecutive cycles; first valid 1 cycle after capture; last=1 only on 0x103F; frame_done 1 cycle later.
- Same vector with ready toggling 1,0,0,1 -> all 64 words in order; spi_word_out/last stable during stalls; no duplicates or drops.
- vec_valid_in pulsed with a different vector at word 10 of a frame -> ignored; frame completes with the original data; vec_ready_out=0 throughout.
- rst_n asserted at word 30, then a new vector element i = 16'hA000+i -> outputs at reset values immediately; no frame_done; new frame starts at 0xA000.
- Vector offered in the frame_done cycle -> accepted; second frame's word 0 is valid exactly 1 cycle later.
- With RESULT_TX_CHECKSUM_EN and element i = i -> 65 words; word 64 = XOR(0..63) = 16'h0000; last only on word 64. Element 0 = 16'hFFFF, others 0 -> checksum 16'hFFFF.
